// File: rtl/mem_stage.sv
// MEM pipeline stage: one outstanding memory access with ack handshake, timeout and bus error.
// Optional build macro MEM_ALIGN_CHECK_EN rejects word-misaligned memory operations.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wregin,
  input  logic        m2regin,
  input  logic        wmemin,
  input  logic [4:0]  RdRtin,
  input  logic [31:0] qbin,
  input  logic [31:0] aluresultin,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wregout,
  output logic        m2regout,
  output logic [4:0]  RdRtout,
  output logic [31:0] aluresultout,
  output logic [31:0] mdataout,
  output logic        bus_err
);

  localparam int unsigned DATA_W = 32;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wreg_q, wreg_d;
  logic              m2reg_q, m2reg_d;
  logic [4:0]        rdrt_q, rdrt_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              bus_err_q, bus_err_d;
  logic              memop;
  logic              misalign;
  logic              stall_c;

  assign memop = m2regin | wmemin;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = |aluresultin[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wreg_d      = wreg_q;
    m2reg_d     = m2reg_q;
    rdrt_d      = rdrt_q;
    alu_d       = alu_q;
    mdata_d     = mdata_q;
    bus_err_d   = 1'b0;
    stall_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memop && misalign) begin
          // Rejected access retires as a bubble without ever touching the bus.
          wreg_d    = 1'b0;
          m2reg_d   = 1'b0;
          bus_err_d = 1'b1;
        end else if (memop) begin
          stall_c     = 1'b1;
          state_d     = S_WAIT;
          cnt_d       = 8'd0;
          mem_addr_d  = aluresultin;
          mem_wdata_d = qbin;
          mem_we_d    = wmemin;
          wreg_d      = 1'b0;
          m2reg_d     = 1'b0;
        end else begin
          wreg_d  = wregin;
          m2reg_d = m2regin;
          rdrt_d  = RdRtin;
          alu_d   = aluresultin;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_ack) begin
          // Ack wins over a simultaneous timeout; the held instruction retires now.
          state_d = S_IDLE;
          wreg_d  = wregin;
          m2reg_d = m2regin;
          rdrt_d  = RdRtin;
          alu_d   = aluresultin;
          if (m2regin) begin
            mdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
          wreg_d    = 1'b0;
          m2reg_d   = 1'b0;
        end else begin
          stall_c = 1'b1;
          wreg_d  = 1'b0;
          m2reg_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wreg_q      <= 1'b0;
      m2reg_q     <= 1'b0;
      rdrt_q      <= 5'd0;
      alu_q       <= '0;
      mdata_q     <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wreg_q      <= wreg_d;
      m2reg_q     <= m2reg_d;
      rdrt_q      <= rdrt_d;
      alu_q       <= alu_d;
      mdata_q     <= mdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req      = (state_q == S_WAIT);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign stall        = stall_c & ~rst;
  assign wregout      = wreg_q;
  assign m2regout     = m2reg_q;
  assign RdRtout      = rdrt_q;
  assign aluresultout = alu_q;
  assign mdataout     = mdata_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level reference model, directed and random traffic.
// Two instances (TIMEOUT=8 and TIMEOUT=4) share the stimulus; use4 selects which one is checked.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wregin, m2regin, wmemin, mem_ack;
  logic [4:0]  RdRtin;
  logic [31:0] qbin, aluresultin, mem_rdata;

  logic        mem_req_a, mem_we_a, stall_a, wregout_a, m2regout_a, bus_err_a;
  logic [31:0] mem_addr_a, mem_wdata_a, aluresultout_a, mdataout_a;
  logic [4:0]  RdRtout_a;
  logic        mem_req_b, mem_we_b, stall_b, wregout_b, m2regout_b, bus_err_b;
  logic [31:0] mem_addr_b, mem_wdata_b, aluresultout_b, mdataout_b;
  logic [4:0]  RdRtout_b;

  logic        use4;
  logic        mem_req_o, mem_we_o, stall_o, wregout_o, m2regout_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, aluresultout_o, mdataout_o;
  logic [4:0]  RdRtout_o;

  assign mem_req_o      = use4 ? mem_req_b      : mem_req_a;
  assign mem_we_o       = use4 ? mem_we_b       : mem_we_a;
  assign stall_o        = use4 ? stall_b        : stall_a;
  assign wregout_o      = use4 ? wregout_b      : wregout_a;
  assign m2regout_o     = use4 ? m2regout_b     : m2regout_a;
  assign bus_err_o      = use4 ? bus_err_b      : bus_err_a;
  assign mem_addr_o     = use4 ? mem_addr_b     : mem_addr_a;
  assign mem_wdata_o    = use4 ? mem_wdata_b    : mem_wdata_a;
  assign aluresultout_o = use4 ? aluresultout_b : aluresultout_a;
  assign mdataout_o     = use4 ? mdataout_b     : mdataout_a;
  assign RdRtout_o      = use4 ? RdRtout_b      : RdRtout_a;

  mem_stage #(.TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .wregin(wregin), .m2regin(m2regin), .wmemin(wmemin),
    .RdRtin(RdRtin), .qbin(qbin), .aluresultin(aluresultin),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall_a),
    .wregout(wregout_a), .m2regout(m2regout_a), .RdRtout(RdRtout_a),
    .aluresultout(aluresultout_a), .mdataout(mdataout_a), .bus_err(bus_err_a)
  );

  mem_stage #(.TIMEOUT(4)) u_dut_to4 (
    .clk(clk), .rst(rst), .wregin(wregin), .m2regin(m2regin), .wmemin(wmemin),
    .RdRtin(RdRtin), .qbin(qbin), .aluresultin(aluresultin),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall_b),
    .wregout(wregout_b), .m2regout(m2regout_b), .RdRtout(RdRtout_b),
    .aluresultout(aluresultout_b), .mdataout(mdataout_b), .bus_err(bus_err_b)
  );

  int n_total = 0;
  int n_pass  = 0;
  int tmo;

  // Architectural expectations: values the MEM/WB register and bus latch should hold.
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_mdata, e_addr, e_wdata;
  logic        e_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic m2, input logic wm, input logic [4:0] rd,
                       input logic [31:0] qb, input logic [31:0] alu);
    wregin = w; m2regin = m2; wmemin = wm; RdRtin = rd; qbin = qb; aluresultin = alu;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".wreg"},  {31'd0, wregout_o},  32'd0);
    chk({tag, ".m2reg"}, {31'd0, m2regout_o}, 32'd0);
    chk({tag, ".rd"},    {27'd0, RdRtout_o},  {27'd0, e_rd});
    chk({tag, ".alu"},   aluresultout_o,      e_alu);
    chk({tag, ".mdata"}, mdataout_o,          e_mdata);
  endtask

  task automatic chk_bus(input string tag);
    chk({tag, ".addr"},  mem_addr_o,          e_addr);
    chk({tag, ".wdata"}, mem_wdata_o,         e_wdata);
    chk({tag, ".we"},    {31'd0, mem_we_o},   {31'd0, e_we});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd3, $urandom, $urandom);
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1 chk("rst.stall_comb", {31'd0, stall_o}, 32'd0);
    tick();
    e_rd = '0; e_alu = '0; e_mdata = '0; e_addr = '0; e_wdata = '0; e_we = 1'b0;
    chk("rst.stall", {31'd0, stall_o}, 32'd0);
    chk("rst.req", {31'd0, mem_req_o}, 32'd0);
    chk("rst.bus_err", {31'd0, bus_err_o}, 32'd0);
    chk_bubble("rst");
    chk_bus("rst");
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic run_pass(input logic w, input logic [4:0] rd, input logic [31:0] alu,
                          input logic ack_noise);
    drive(w, 1'b0, 1'b0, rd, $urandom, alu);
    mem_ack = ack_noise; mem_rdata = $urandom;
    #1 chk("pass.stall", {31'd0, stall_o}, 32'd0);
    chk("pass.req", {31'd0, mem_req_o}, 32'd0);
    tick();
    mem_ack = 1'b0;
    e_rd = rd; e_alu = alu;
    chk("pass.wreg", {31'd0, wregout_o}, {31'd0, w});
    chk("pass.m2reg", {31'd0, m2regout_o}, 32'd0);
    chk("pass.rd", {27'd0, RdRtout_o}, {27'd0, rd});
    chk("pass.alu", aluresultout_o, alu);
    chk("pass.mdata", mdataout_o, e_mdata);
    chk("pass.bus_err", {31'd0, bus_err_o}, 32'd0);
    chk_bus("pass.idle");
  endtask

  // ack_at: WAIT cycle (1-based) in which ack is raised; beyond tmo means no ack at all.
  task automatic run_mem(input logic is_load, input logic w, input logic [4:0] rd,
                         input logic [31:0] qb, input logic [31:0] alu,
                         input logic [31:0] rdata, input int ack_at);
    drive(w, is_load, !is_load, rd, qb, alu);
    mem_ack = 1'b0; mem_rdata = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
    if (alu[1:0] != 2'b00) begin
      #1 chk("align.stall", {31'd0, stall_o}, 32'd0);
      chk("align.req", {31'd0, mem_req_o}, 32'd0);
      tick();
      chk("align.bus_err", {31'd0, bus_err_o}, 32'd1);
      chk("align.req_after", {31'd0, mem_req_o}, 32'd0);
      chk_bubble("align");
      chk_bus("align");
      return;
    end
`endif
    #1 chk("mem.stall_idle", {31'd0, stall_o}, 32'd1);
    chk("mem.req_idle", {31'd0, mem_req_o}, 32'd0);
    tick();
    e_addr = alu; e_wdata = qb; e_we = !is_load;
    for (int k = 1; k <= tmo; k++) begin
      chk("wait.req", {31'd0, mem_req_o}, 32'd1);
      chk("wait.bus_err", {31'd0, bus_err_o}, 32'd0);
      chk_bus("wait");
      chk_bubble("wait");
      if (k == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rdata;
        #1 chk("ack.stall", {31'd0, stall_o}, 32'd0);
        tick();
        mem_ack = 1'b0;
        e_rd = rd; e_alu = alu;
        if (is_load) e_mdata = rdata;
        chk("ack.wreg", {31'd0, wregout_o}, {31'd0, w});
        chk("ack.m2reg", {31'd0, m2regout_o}, {31'd0, is_load});
        chk("ack.rd", {27'd0, RdRtout_o}, {27'd0, rd});
        chk("ack.alu", aluresultout_o, alu);
        chk("ack.mdata", mdataout_o, e_mdata);
        chk("ack.bus_err", {31'd0, bus_err_o}, 32'd0);
        chk("ack.req", {31'd0, mem_req_o}, 32'd0);
        return;
      end
      #1 chk("wait.stall", {31'd0, stall_o}, (k < tmo) ? 32'd1 : 32'd0);
      tick();
    end
    chk("tmo.bus_err", {31'd0, bus_err_o}, 32'd1);
    chk("tmo.req", {31'd0, mem_req_o}, 32'd0);
    chk_bubble("tmo");
    chk_bus("tmo");
  endtask

  task automatic reset_in_wait();
    drive(1'b1, 1'b1, 1'b0, 5'd12, 32'd0, 32'h0000_0100);
    mem_ack = 1'b0;
    tick();
    tick();
    chk("rstw.req", {31'd0, mem_req_o}, 32'd1);
    rst = 1'b1;
    #1 chk("rstw.stall_comb", {31'd0, stall_o}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    e_rd = '0; e_alu = '0; e_mdata = '0; e_addr = '0; e_wdata = '0; e_we = 1'b0;
    chk("rstw.req_after", {31'd0, mem_req_o}, 32'd0);
    chk("rstw.stall", {31'd0, stall_o}, 32'd0);
    chk("rstw.bus_err", {31'd0, bus_err_o}, 32'd0);
    chk_bubble("rstw");
    chk_bus("rstw");
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (kind == 0)
        run_pass(1'($urandom), 5'($urandom), a, 1'($urandom));
      else
        run_mem(kind == 1, 1'($urandom), 5'($urandom), $urandom, a, $urandom,
                $urandom_range(1, tmo + 1));
    end
  endtask

  initial begin
    use4 = 1'b0; tmo = 8;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    do_reset();
    run_pass(1'b1, 5'd5, 32'h0000_1234, 1'b0);
    run_mem(1'b1, 1'b1, 5'd3, 32'h1357_9BDF, 32'h0000_0040, 32'hDEAD_BEEF, 1);
    run_mem(1'b0, 1'b0, 5'd7, 32'hCAFE_0001, 32'h0000_0080, 32'h0BAD_0BAD, 5);
    run_pass(1'b1, 5'd9, 32'hA5A5_0000, 1'b1);
    run_mem(1'b1, 1'b1, 5'd9, 32'd0, 32'h0000_0042, 32'h1111_2222, 2);
    run_mem(1'b1, 1'b1, 5'd4, 32'd0, 32'h0000_0010, 32'h3333_4444, 1);
    run_mem(1'b0, 1'b0, 5'd6, 32'h5555_6666, 32'h0000_0014, 32'd0, 2);
    run_mem(1'b1, 1'b1, 5'd8, 32'd0, 32'h0000_0020, 32'h7777_8888, 9);
    reset_in_wait();
    random_ops(40);

    use4 = 1'b1; tmo = 4;
    do_reset();
    run_mem(1'b1, 1'b1, 5'd2, 32'd0, 32'h0000_0200, 32'h9999_AAAA, 5);
    run_pass(1'b1, 5'd11, 32'h0000_0BCD, 1'b0);
    run_mem(1'b1, 1'b1, 5'd2, 32'd0, 32'h0000_0204, 32'hBBBB_CCCC, 4);
    random_ops(25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
